// File: rtl/alu_pkg.sv
// Shared constants and helpers for the MIPS ALU and its sharing arbiter.
package alu_pkg;

   localparam int unsigned ALU_W = 32;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;

   function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
      logic legal;
      legal = 1'b0;
      case (ctrl)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; prio names the port that wins a tie.
module rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic prio;
   logic prio_next;

   always_comb begin
      gnt       = 2'b00;
      prio_next = prio;
      if (en) begin
         if (req[0] && (!req[1] || !prio)) begin
            gnt = 2'b01;
         end else if (req[1]) begin
            gnt = 2'b10;
         end
      end
      // After a grant the other port gets priority.
      if (gnt != 2'b00) begin
         prio_next = gnt[0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prio <= 1'b0;
      end else begin
         prio <= prio_next;
      end
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters: round-robin grant, issue register,
// result register and per-port response pulse (2-cycle latency).
module alu_share_arb
   import alu_pkg::*;
#(
   parameter int unsigned W = ALU_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         stall,
   input  logic         r0_valid,
   output logic         r0_ready,
   input  logic [3:0]   r0_ctrl,
   input  logic [W-1:0] r0_a,
   input  logic [W-1:0] r0_b,
   input  logic         r1_valid,
   output logic         r1_ready,
   input  logic [3:0]   r1_ctrl,
   input  logic [W-1:0] r1_a,
   input  logic [W-1:0] r1_b,
   output logic [3:0]   alu_ctrl,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_out,
   input  logic         alu_zero,
   output logic         r0_rvalid,
   output logic         r1_rvalid,
   output logic [W-1:0] rdata,
   output logic         rzero,
   output logic         rerr
);

   logic [1:0]   gnt;
   logic         iv;
   logic         iown;
   logic [3:0]   ictrl;
   logic [W-1:0] ia;
   logic [W-1:0] ib;
   logic         qv;
   logic         qown;

   rr_arb2 u_arb (
      .clock (clock),
      .reset (reset),
      .en    (!stall && !reset),
      .req   ({r1_valid, r0_valid}),
      .gnt   (gnt)
   );

   assign r0_ready = gnt[0];
   assign r1_ready = gnt[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         iv    <= 1'b0;
         iown  <= 1'b0;
         ictrl <= 4'd0;
         ia    <= '0;
         ib    <= '0;
      end else if (gnt != 2'b00) begin
         iv    <= 1'b1;
         iown  <= gnt[1];
         ictrl <= gnt[1] ? r1_ctrl : r0_ctrl;
         ia    <= gnt[1] ? r1_a : r0_a;
         ib    <= gnt[1] ? r1_b : r0_b;
      end else begin
         iv <= 1'b0;
      end
   end

   always_comb begin
      alu_ctrl = 4'd0;
      alu_a    = '0;
      alu_b    = '0;
      if (iv) begin
         alu_ctrl = ictrl;
         alu_a    = ia;
         alu_b    = ib;
      end
   end

   // Payload holds its last value between responses; only qv is pulsed.
   always_ff @(posedge clock) begin
      if (reset) begin
         qv    <= 1'b0;
         qown  <= 1'b0;
         rdata <= '0;
         rzero <= 1'b0;
         rerr  <= 1'b0;
      end else begin
         qv <= iv;
         if (iv) begin
            qown  <= iown;
            rdata <= alu_out;
            rzero <= alu_zero;
            rerr  <= !alu_ctrl_legal(ictrl);
         end
      end
   end

   assign r0_rvalid = qv && !qown;
   assign r1_rvalid = qv && qown;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: vector table, hand sequences and an
// in-order response scoreboard with latency check.
module tb_alu_share_arb;
   import alu_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        r0_valid = 1'b0, r1_valid = 1'b0;
   logic        r0_ready, r1_ready;
   logic [3:0]  r0_ctrl = 4'd0, r1_ctrl = 4'd0;
   logic [31:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_a, alu_b, alu_out;
   logic        alu_zero;
   logic        r0_rvalid, r1_rvalid;
   logic [31:0] rdata;
   logic        rzero, rerr;

   typedef struct {
      logic [31:0] d;
      logic        z;
      logic        e;
   } exp_t;

   typedef struct {
      logic        own;
      exp_t        x;
      int          cyc;
   } sb_t;

   typedef struct {
      logic        own;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        z;
      logic        e;
   } vec_t;

   exp_t exp0, exp1;
   sb_t  sbq[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   alu_share_arb #(.W(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .stall     (stall),
      .r0_valid  (r0_valid),
      .r0_ready  (r0_ready),
      .r0_ctrl   (r0_ctrl),
      .r0_a      (r0_a),
      .r0_b      (r0_b),
      .r1_valid  (r1_valid),
      .r1_ready  (r1_ready),
      .r1_ctrl   (r1_ctrl),
      .r1_a      (r1_a),
      .r1_b      (r1_b),
      .alu_ctrl  (alu_ctrl),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_out   (alu_out),
      .alu_zero  (alu_zero),
      .r0_rvalid (r0_rvalid),
      .r1_rvalid (r1_rvalid),
      .rdata     (rdata),
      .rzero     (rzero),
      .rerr      (rerr)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      case (c)
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_NOR: r = ~(a | b);
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // External shared ALU.
   always_comb begin
      alu_out  = ref_alu(alu_ctrl, alu_a, alu_b);
      alu_zero = (alu_out == 32'd0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard: push on accept, pop on response.
   always @(negedge clock) begin
      if (reset) begin
         sbq.delete();
      end else begin
         if (r0_rvalid && r1_rvalid) check("both_rvalid", 32'd1, 32'd0);
         if (r0_rvalid || r1_rvalid) begin
            if (sbq.size() == 0) begin
               check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
               sb_t e;
               e = sbq.pop_front();
               check("rsp_owner", {31'd0, r1_rvalid}, {31'd0, e.own});
               check("rsp_rdata", rdata, e.x.d);
               check("rsp_rzero", {31'd0, rzero}, {31'd0, e.x.z});
               check("rsp_rerr", {31'd0, rerr}, {31'd0, e.x.e});
               check("rsp_latency", cyc - e.cyc, 32'd2);
            end
         end
         if (r0_valid && r0_ready) sbq.push_back('{own: 1'b0, x: exp0, cyc: cyc});
         if (r1_valid && r1_ready) sbq.push_back('{own: 1'b1, x: exp1, cyc: cyc});
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic set_port(input logic p, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] d, input logic z,
                           input logic e);
      if (!p) begin
         r0_ctrl = c; r0_a = a; r0_b = b; exp0 = '{d: d, z: z, e: e}; r0_valid = 1'b1;
      end else begin
         r1_ctrl = c; r1_a = a; r1_b = b; exp1 = '{d: d, z: z, e: e}; r1_valid = 1'b1;
      end
   endtask

   // Request on one port and hold until granted; returns just after the accepting edge.
   task automatic issue(input logic p, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] d, input logic z,
                        input logic e);
      bit done;
      done = 0;
      set_port(p, c, a, b, d, z, e);
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clock);
         done = p ? r1_ready : r0_ready;
         next_cycle();
      end
      if (!done) check("grant_timeout", 32'd0, 32'd1);
      r0_valid = 1'b0;
      r1_valid = 1'b0;
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
      vecs[1] = '{1'b1, ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[2] = '{1'b0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, ALU_SLT, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[5] = '{1'b1, ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 4'd3, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 4'd15, 32'd8, 32'd8, 32'd0, 1'b1, 1'b1};
      vecs[8] = '{1'b0, ALU_OR, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0};

      repeat (2) next_cycle();
      reset = 1'b0;

      // Reset state
      @(negedge clock);
      check("rst_flags", {26'd0, r0_ready, r1_ready, r0_rvalid, r1_rvalid, rzero, rerr}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_alu", {28'd0, alu_ctrl} | alu_a | alu_b, 32'd0);
      next_cycle();

      // Single request with cycle-accurate ALU drive
      set_port(1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
      @(negedge clock);
      check("single_grant", {30'd0, r1_ready, r0_ready}, 32'd1);
      next_cycle();
      r0_valid = 1'b0;
      @(negedge clock);
      check("single_alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
      check("single_alu_a", alu_a, 32'd5);
      check("single_alu_b", alu_b, 32'd7);
      next_cycle();
      next_cycle();
      @(negedge clock);
      check("hold_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
      check("hold_rdata", rdata, 32'd12);
      next_cycle();

      // Vector table
      foreach (vecs[i]) issue(vecs[i].own, vecs[i].ctrl, vecs[i].a, vecs[i].b,
                              vecs[i].d, vecs[i].z, vecs[i].e);
      repeat (3) next_cycle();

      // Contention from reset: r0, r1, r0, r1
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      set_port(1'b0, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
      set_port(1'b1, ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("contend_grant", {30'd0, r1_ready, r0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
         next_cycle();
      end
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      repeat (3) next_cycle();

      // Stall with one op in flight; prio becomes 1 after the r0 grant
      issue(1'b0, ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
      stall = 1'b1;
      set_port(1'b0, ALU_AND, 32'd3, 32'd1, 32'd1, 1'b0, 1'b0);
      set_port(1'b1, ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("stall_grant", {30'd0, r1_ready, r0_ready}, 32'd0);
         next_cycle();
      end
      stall = 1'b0;
      @(negedge clock);
      check("unstall_grant1", {30'd0, r1_ready, r0_ready}, 32'd2);
      next_cycle();
      @(negedge clock);
      check("unstall_grant2", {30'd0, r1_ready, r0_ready}, 32'd1);
      next_cycle();
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      repeat (3) next_cycle();

      // Reset mid-flight: SLT accepted, then reset; no response, prio back to 0
      issue(1'b0, ALU_SLT, 32'd1, 32'd2, 32'd1, 1'b0, 1'b0);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      set_port(1'b0, ALU_AND, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0);
      set_port(1'b1, ALU_ADD, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0);
      @(negedge clock);
      check("rst_mid_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
      check("rst_mid_rdata", rdata, 32'd0);
      check("rst_mid_flags", {30'd0, rzero, rerr}, 32'd0);
      check("rst_mid_alu", {28'd0, alu_ctrl} | alu_a | alu_b, 32'd0);
      check("rst_mid_prio", {30'd0, r1_ready, r0_ready}, 32'd1);
      next_cycle();
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      repeat (3) next_cycle();

      // Back-to-back r0 AND/NOR with random operands
      for (int i = 0; i < 8; i++) begin
         logic [3:0]  c;
         logic [31:0] a, b, d;
         c = ($urandom_range(0, 1) == 0) ? ALU_AND : ALU_NOR;
         a = $urandom;
         b = $urandom;
         d = ref_alu(c, a, b);
         issue(1'b0, c, a, b, d, (d == 32'd0), 1'b0);
      end
      repeat (4) next_cycle();
      check("drain_empty", sbq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and issue pipeline that shares the single 32-bit MIPS ALU between two requesters: port 0 (main execute stage) and port 1 (branch/address helper). Grants are round-robin, operands are registered before driving the ALU, and ALU results are registered and returned to the winning port as a one-cycle response pulse. The ALU itself lives outside this block and is wired to the `alu_*` ports.

## Interface
- `W`, 32, datapath width. Fixed at 32 for this CPU.
- `clock  in  1`  system clock; all state updates on rising edge.
- `reset  in  1`  synchronous, active-high.
- `stall  in  1`  blocks new grants; in-flight operations still drain.
- `r0_valid  in  1`  port 0 request; must hold with stable payload until `r0_ready`.
- `r0_ready  out  1`  port 0 grant; combinational.
- `r0_ctrl  in  4`  ALU control code.
- `r0_a, r0_b  in  32`  operands.
- `r1_valid, r1_ready, r1_ctrl, r1_a, r1_b`: same as port 0, for port 1.
- `alu_ctrl  out  4`, `alu_a  out  32`, `alu_b  out  32`  drive the shared ALU.
- `alu_out  in  32`, `alu_zero  in  1`  combinational ALU result and zero flag.
- `r0_rvalid  out  1`, `r1_rvalid  out  1`  one-cycle response pulse to the owning port.
- `rdata  out  32`, `rzero  out  1`  response result and zero flag, shared by both ports.
- `rerr  out  1`  response carries an illegal control code.

## Operation
- Legal ctrl codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR. Any other code is accepted and passed to the ALU, which returns 0. The response then has `rerr`=1.
- Grant rule, when `stall`=0 and `reset`=0:
  - Only one port valid: that port is granted.
  - Both ports valid: the port named by `prio` is granted.
  - Exactly one `rX_ready` is high per granted cycle. Both readys are 0 when `stall`=1 or `reset`=1.
- `prio` is 1 bit and resets to 0. After each grant it is set to the other port. It is unchanged on cycles with no grant.
- Issue register holds `iv`, `iown`, `ictrl`, `ia`, `ib`:
  - Loaded on a grant.
  - Otherwise `iv` is cleared.
  - It never holds longer than one cycle, because there is no response backpressure.
- `alu_ctrl/alu_a/alu_b` = issue register contents when `iv`=1, otherwise all zero.
- Result register holds `qv`, `qown`, `rdata`, `rzero`, `rerr`:
  - Loaded from `alu_out`, `alu_zero` and the legality check whenever `iv`=1.
  - `qv` follows `iv`.
- `r0_rvalid` = `qv` & `qown`==0. `r1_rvalid` = `qv` & `qown`==1.
- `rdata/rzero/rerr` are valid only while an `rvalid` is high. They hold their last value otherwise.
- Throughput: 1 operation per cycle in total. Under continuous contention the two ports alternate.

## Timing
- Cycle k: `rX_valid`=1 and `rX_ready`=1, so the request is accepted at the end of k.
- Cycle k+1: `alu_*` are driven from the issue register.
- Cycle k+2: `rX_rvalid`=1 with the result. Latency is 2 cycles and fully pipelined.
- Reset values (registered state and all outputs): `prio`=0, `iv`=0, `qv`=0, all readys/rvalids 0, `alu_*`=0, `rdata`=0, `rzero`=0, `rerr`=0.
- Reset mid-operation: in-flight issue and result are discarded. No `rvalid` appears in the cycle after reset is asserted.
- `stall` rising while ops are in flight: no new grants from that cycle. Queued ops still produce `rvalid` at k+2. When `stall` falls, granting resumes the same cycle, with `prio` unchanged.
- Requester drops valid without ready: legal; nothing is issued.

## Structure
- Package `alu_pkg` contains:
  - localparams `ALU_AND`=0, `ALU_OR`=1, `ALU_ADD`=2, `ALU_SUB`=6, `ALU_SLT`=7, `ALU_NOR`=12.
  - `ALU_W`=32.
  - function `alu_ctrl_legal(ctrl)`.
- Sub-module `rr_arb2`: 2-request round-robin arbiter holding `prio`, with inputs `req[1:0]` and `en`, and output one-hot `gnt[1:0]`.
- Top level contains the issue register, the result register and the response decode.

## Test plan
- Single request: r0 ADD, a=5, b=7, accepted cycle 0 → `alu_ctrl`=2 in cycle 1 → `r0_rvalid`=1, `rdata`=12, `rzero`=0 in cycle 2. `r1_rvalid` stays 0.
- Contention: both ports valid for 4 cycles from reset (r0 SUB 9-9, r1 OR 0xF0|0x0F) → grants r0, r1, r0, r1 → responses: r0 `rdata`=0 with `rzero`=1, and r1 `rdata`=0xFF, alternating.
- Stall: `stall`=1 while both ports are valid → no readys. One op already in flight still returns at k+2. `stall`=0 → grant resumes for the `prio` port.
- Illegal ctrl: r1 ctrl=3, a=1, b=1 → `r1_rvalid` with `rdata`=0, `rzero`=1, `rerr`=1.
- Reset mid-flight: grant SLT 1<2 at cycle k, `reset`=1 at cycle k+1 → no `rvalid` in cycle k+2. After reset all outputs are 0 and `prio`=0.
- Back-to-back r0 only, 8 cycles of AND/NOR with random operands → 8 consecutive `r0_rvalid` pulses, with results matching the reference model in order.
